wb_swt_master: RTL

WB_SWT_MASTER -- requirements
Module: wb_swt_master

---
 rtl/wb_swt_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_swt_master.sv
// SWT bridge: takes request words from the DP0 FIFO, runs one Wishbone cycle, returns read data via DP1.
// Optional macro WB_SWT_ERR_REPORT_EN: err/timeout produces a {1, adr, 16'hDEAD} response word.
module wb_swt_master #(
    parameter int GpifWidth       = 32,
    parameter int FifoReadLatency = 2,
    parameter int WbTimeout       = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [GpifWidth-1:0] dp0_dt_i,
    input  logic                 dp0_epty_i,
    output logic                 dp0_rd_o,
    output logic [GpifWidth-1:0] dp1_dt_o,
    input  logic                 dp1_full_i,
    output logic                 dp1_wr_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [14:0]          wbm_adr_o,
    output logic [15:0]          wbm_dat_o,
    input  logic [15:0]          wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic                 busy_o,
    output logic [15:0]          trans_cnt_o,
    output logic [15:0]          err_cnt_o
);

    typedef enum logic [1:0] {IDLE, FETCH, WB_REQ, RESP} state_t;

    localparam logic [7:0] LatLast = 8'(FifoReadLatency - 1);
    localparam logic [7:0] TmoLast = 8'(WbTimeout - 1);

    state_t               state;
    state_t               state_next;
    logic                 run;
    logic [7:0]           lat_cnt;
    logic [7:0]           tmo_cnt;
    logic [GpifWidth-1:0] req_q;
    logic [GpifWidth-1:0] resp_q;
    logic [15:0]          trans_cnt;
    logic [15:0]          err_cnt;
    logic                 req_we;
    logic [14:0]          req_adr;
    logic [15:0]          req_dat;
    logic                 ack_term;
    logic                 fail_term;

    assign req_we  = req_q[31];
    assign req_adr = req_q[30:16];
    assign req_dat = req_q[15:0];

    // err outranks ack; timeout only when the slave stayed silent for the whole window
    always_comb begin
        ack_term  = 1'b0;
        fail_term = 1'b0;
        if (state == WB_REQ) begin
            ack_term  = !wbm_err_i && wbm_ack_i;
            fail_term = wbm_err_i || (!wbm_ack_i && tmo_cnt == TmoLast);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        dp0_rd_o   = 1'b0;
        dp1_wr_o   = 1'b0;
        case (state)
            IDLE: begin
                // run gates the read strobe until the first edge after reset release
                if (run && !dp0_epty_i) begin
                    dp0_rd_o   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (lat_cnt == LatLast) state_next = WB_REQ;
            end
            WB_REQ: begin
                if (ack_term) begin
                    state_next = req_we ? IDLE : RESP;
                end else if (fail_term) begin
`ifdef WB_SWT_ERR_REPORT_EN
                    state_next = RESP;
`else
                    state_next = IDLE;
`endif
                end
            end
            RESP: begin
                if (!dp1_full_i) begin
                    dp1_wr_o   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run       <= 1'b0;
            lat_cnt   <= '0;
            tmo_cnt   <= '0;
            req_q     <= '0;
            resp_q    <= '0;
            trans_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            run     <= 1'b1;
            lat_cnt <= (state == FETCH) ? lat_cnt + 8'd1 : '0;
            tmo_cnt <= (state == WB_REQ) ? tmo_cnt + 8'd1 : '0;
            if (state == FETCH && lat_cnt == LatLast) req_q <= dp0_dt_i;
            if (ack_term && !req_we) resp_q <= {1'b0, req_adr, wbm_dat_i};
`ifdef WB_SWT_ERR_REPORT_EN
            if (fail_term) resp_q <= {1'b1, req_adr, 16'hDEAD};
`endif
            if (ack_term || fail_term) trans_cnt <= trans_cnt + 16'd1;
            if (fail_term && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign wbm_cyc_o   = (state == WB_REQ);
    assign wbm_stb_o   = (state == WB_REQ);
    assign wbm_we_o    = req_we;
    assign wbm_adr_o   = req_adr;
    assign wbm_dat_o   = req_dat;
    assign dp1_dt_o    = resp_q;
    assign busy_o      = (state != IDLE);
    assign trans_cnt_o = trans_cnt;
    assign err_cnt_o   = err_cnt;

endmodule
